// File: rtl/fp_regfile_sb.sv
// Floating-point register file with per-register busy scoreboard and a one-entry
// registered issue stage toward a multicycle FPU; also owns frm and fflags.
module fp_regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int MAX_OUT = 4,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [RA_W-1:0]   issue_rs1,
  input  logic [RA_W-1:0]   issue_rs2,
  input  logic [RA_W-1:0]   issue_rd,
  input  logic [6:0]        issue_funct7,
  input  logic [2:0]        issue_rm,
  output logic              fpu_valid,
  input  logic              fpu_ready,
  output logic [DATA_W-1:0] fpu_rs1_data,
  output logic [DATA_W-1:0] fpu_rs2_data,
  output logic [6:0]        fpu_funct7,
  output logic [2:0]        fpu_frm,
  output logic [RA_W-1:0]   fpu_rd,
  input  logic              wb_valid,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [4:0]        wb_flags,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [RA_W-1:0]   ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [RA_W-1:0]   st_rs,
  output logic [DATA_W-1:0] st_data,
  output logic              st_ok,
  input  logic              frm_we,
  input  logic [2:0]        frm_wdata,
  output logic [2:0]        frm,
  input  logic              fflags_we,
  input  logic [4:0]        fflags_wdata,
  output logic [4:0]        fflags,
  output logic              illegal_rm,
  output logic              spurious_wb
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy, busy_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [4:0]        fflags_nxt;

  logic              wb_hit, rs1_fwd, rs2_fwd, rd_fwd;
  logic              rs1_ok, rs2_ok, rd_ok, cnt_ok, stage_ok;
  logic              issue_fire, issue_go, rm_bad, ld_fire;
  logic [2:0]        rm_res;
  logic [DATA_W-1:0] rs1_val, rs2_val;

  // Handshakes (issue, fpu, ld): a transfer happens on a rising clk edge where
  // valid and ready are both high; once raised, fpu_valid and its payload stay
  // stable until that edge. Ready never depends on the same port's valid.

  // Only a writeback to a busy register is real; a stray one neither forwards
  // nor frees anything.
  assign wb_hit  = wb_valid && busy[wb_rd];
  assign rs1_fwd = wb_hit && (wb_rd == issue_rs1);
  assign rs2_fwd = wb_hit && (wb_rd == issue_rs2);
  assign rd_fwd  = wb_hit && (wb_rd == issue_rd);

  assign rs1_ok   = !busy[issue_rs1] || rs1_fwd;
  assign rs2_ok   = !busy[issue_rs2] || rs2_fwd;
  assign rd_ok    = !busy[issue_rd] || rd_fwd;
  assign cnt_ok   = (count < MAX_CNT) || wb_hit;
  assign stage_ok = !fpu_valid || fpu_ready;

  assign issue_ready = rs1_ok && rs2_ok && rd_ok && cnt_ok && stage_ok;
  assign issue_fire  = issue_valid && issue_ready;

  // Resolved modes 101/110/111 are reserved; the op is consumed but dropped.
  assign rm_res   = (issue_rm == 3'b111) ? frm : issue_rm;
  assign rm_bad   = rm_res[2] && (rm_res[1] || rm_res[0]);
  assign issue_go = issue_fire && !rm_bad;

  assign rs1_val = rs1_fwd ? wb_data : regs[issue_rs1];
  assign rs2_val = rs2_fwd ? wb_data : regs[issue_rs2];

  assign ld_ready = !busy[ld_rd];
  assign ld_fire  = ld_valid && ld_ready;

  assign st_data = regs[st_rs];
  assign st_ok   = !busy[st_rs];

  always_comb begin
    busy_nxt = busy;
    if (wb_hit)   busy_nxt[wb_rd]    = 1'b0;
    if (issue_go) busy_nxt[issue_rd] = 1'b1;
  end

  always_comb begin
    count_nxt = count;
    case ({issue_go, wb_hit})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    fflags_nxt = fflags;
    if (fflags_we)   fflags_nxt = fflags_wdata | (wb_hit ? wb_flags : 5'b0);
    else if (wb_hit) fflags_nxt = fflags | wb_flags;
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      // wb targets a busy register and a load a non-busy one, so they never collide.
      if (wb_hit)  regs[wb_rd] <= wb_data;
      if (ld_fire) regs[ld_rd] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      busy        <= '0;
      count       <= '0;
      frm         <= 3'b000;
      fflags      <= 5'b00000;
      illegal_rm  <= 1'b0;
      spurious_wb <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      count      <= count_nxt;
      fflags     <= fflags_nxt;
      illegal_rm <= issue_fire && rm_bad;
      if (frm_we) frm <= frm_wdata;
      if (wb_valid && !busy[wb_rd]) spurious_wb <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      fpu_valid    <= 1'b0;
      fpu_rs1_data <= '0;
      fpu_rs2_data <= '0;
      fpu_funct7   <= 7'd0;
      fpu_frm      <= 3'b000;
      fpu_rd       <= '0;
    end else if (issue_go) begin
      fpu_valid    <= 1'b1;
      fpu_rs1_data <= rs1_val;
      fpu_rs2_data <= rs2_val;
      fpu_funct7   <= issue_funct7;
      fpu_frm      <= rm_res;
      fpu_rd       <= issue_rd;
    end else if (fpu_ready) begin
      fpu_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Directed bench for fp_regfile_sb: rounding-mode table plus hand sequences for
// hazards, forwarding, outstanding limit, back-pressure, flags and reset.
module tb_fp_regfile_sb;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              issue_valid, issue_ready;
  logic [RA_W-1:0]   issue_rs1, issue_rs2, issue_rd;
  logic [6:0]        issue_funct7;
  logic [2:0]        issue_rm;
  logic              fpu_valid, fpu_ready;
  logic [DATA_W-1:0] fpu_rs1_data, fpu_rs2_data;
  logic [6:0]        fpu_funct7;
  logic [2:0]        fpu_frm;
  logic [RA_W-1:0]   fpu_rd;
  logic              wb_valid;
  logic [RA_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_flags;
  logic              ld_valid, ld_ready;
  logic [RA_W-1:0]   ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic [RA_W-1:0]   st_rs;
  logic [DATA_W-1:0] st_data;
  logic              st_ok;
  logic              frm_we;
  logic [2:0]        frm_wdata, frm;
  logic              fflags_we;
  logic [4:0]        fflags_wdata, fflags;
  logic              illegal_rm, spurious_wb;

  fp_regfile_sb dut (
    .clk(clk), .n_rst(n_rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_funct7(issue_funct7), .issue_rm(issue_rm),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready),
    .fpu_rs1_data(fpu_rs1_data), .fpu_rs2_data(fpu_rs2_data),
    .fpu_funct7(fpu_funct7), .fpu_frm(fpu_frm), .fpu_rd(fpu_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_flags(wb_flags),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .st_rs(st_rs), .st_data(st_data), .st_ok(st_ok),
    .frm_we(frm_we), .frm_wdata(frm_wdata), .frm(frm),
    .fflags_we(fflags_we), .fflags_wdata(fflags_wdata), .fflags(fflags),
    .illegal_rm(illegal_rm), .spurious_wb(spurious_wb)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    logic [2:0] rm;
    logic [2:0] frm_v;
    logic [2:0] exp_frm;
    logic       exp_ill;
  } rm_vec_t;
  rm_vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // driver tasks
  task automatic issue_set(input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                           input logic [RA_W-1:0] rd, input logic [2:0] rm);
    issue_valid  = 1'b1;
    issue_rs1    = rs1;
    issue_rs2    = rs2;
    issue_rd     = rd;
    issue_rm     = rm;
    issue_funct7 = 7'h05;
  endtask

  task automatic wb_set(input logic [RA_W-1:0] rd, input logic [DATA_W-1:0] d,
                        input logic [4:0] fl);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = d;
    wb_flags = fl;
  endtask

  task automatic wb_clr();
    wb_valid = 1'b0;
    wb_flags = 5'b0;
  endtask

  task automatic do_wb(input logic [RA_W-1:0] rd, input logic [DATA_W-1:0] d);
    wb_set(rd, d, 5'b0);
    tick();
    wb_clr();
  endtask

  initial begin
    vecs[0] = '{3'b000, 3'b010, 3'b000, 1'b0};
    vecs[1] = '{3'b111, 3'b010, 3'b010, 1'b0};
    vecs[2] = '{3'b111, 3'b101, 3'b000, 1'b1};
    vecs[3] = '{3'b101, 3'b000, 3'b000, 1'b1};
    vecs[4] = '{3'b110, 3'b000, 3'b000, 1'b1};
    vecs[5] = '{3'b100, 3'b111, 3'b100, 1'b0};
    vecs[6] = '{3'b111, 3'b100, 3'b100, 1'b0};
    vecs[7] = '{3'b111, 3'b111, 3'b000, 1'b1};
    vecs[8] = '{3'b011, 3'b001, 3'b011, 1'b0};

    n_rst = 1'b1;
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    issue_funct7 = '0; issue_rm = '0; fpu_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; wb_flags = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0; st_rs = '0;
    frm_we = 1'b0; frm_wdata = '0; fflags_we = 1'b0; fflags_wdata = '0;
    repeat (2) tick();
    n_rst = 1'b0;
    tick();

    // reset in the middle of a staged op
    frm_we = 1'b1; frm_wdata = 3'b011;
    issue_set(5'd1, 5'd2, 5'd5, 3'b000);
    tick();
    issue_valid = 1'b0; frm_we = 1'b0;
    chk("stage_before_rst", fpu_valid, 1);
    n_rst = 1'b1;
    st_rs = 5'd5;
    settle();
    chk("rst_fpu_valid", fpu_valid, 0);
    chk("rst_fpu_rd", fpu_rd, 0);
    chk("rst_busy5", st_ok, 1);
    chk("rst_frm", frm, 0);
    tick();
    n_rst = 1'b0;
    tick();
    chk("rst_fflags", fflags, 0);
    chk("rst_illegal", illegal_rm, 0);
    chk("rst_spurious", spurious_wb, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_fpu_data", fpu_rs1_data, 0);

    // loads then store-port readback
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'hA1A1_0001;
    settle();
    chk("ld_ready_idle", ld_ready, 1);
    exp_q.push_back(32'hA1A1_0001);
    tick();
    ld_rd = 5'd2; ld_data = 32'hB2B2_0002;
    exp_q.push_back(32'hB2B2_0002);
    tick();
    ld_valid = 1'b0;
    for (int r = 1; r <= 2; r++) begin
      st_rs = RA_W'(r);
      settle();
      chk("ld_st_data", st_data, exp_q.pop_front());
    end

    // RAW stall, load to busy rd, writeback forwarding
    issue_set(5'd1, 5'd2, 5'd3, 3'b000);
    settle();
    chk("raw_first_ready", issue_ready, 1);
    tick();
    issue_set(5'd3, 5'd1, 5'd6, 3'b000);
    st_rs = 5'd3; ld_rd = 5'd3;
    settle();
    chk("op3_rs1", fpu_rs1_data, 32'hA1A1_0001);
    chk("op3_rs2", fpu_rs2_data, 32'hB2B2_0002);
    chk("op3_rd", fpu_rd, 3);
    chk("op3_funct7", fpu_funct7, 7'h05);
    chk("raw_stall", issue_ready, 0);
    chk("busy3_st_ok", st_ok, 0);
    chk("ld_busy_rd", ld_ready, 0);
    tick();
    chk("raw_still_stall", issue_ready, 0);
    wb_set(5'd3, 32'h3F80_0000, 5'b0);
    settle();
    chk("raw_fwd_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0; wb_clr();
    settle();
    chk("fwd_rs1", fpu_rs1_data, 32'h3F80_0000);
    chk("fwd_rs2", fpu_rs2_data, 32'hA1A1_0001);
    chk("fwd_rd", fpu_rd, 6);
    chk("wb3_st_data", st_data, 32'h3F80_0000);
    chk("wb3_st_ok", st_ok, 1);
    st_rs = 5'd6;
    settle();
    chk("busy6", st_ok, 0);
    do_wb(5'd6, 32'h0);

    // outstanding limit
    for (int i = 1; i <= 4; i++) begin
      issue_set(5'd0, 5'd0, RA_W'(i), 3'b000);
      settle();
      chk("out_ready", issue_ready, 1);
      tick();
    end
    issue_set(5'd0, 5'd0, 5'd7, 3'b000);
    settle();
    chk("out_fifth_stall", issue_ready, 0);
    tick();
    chk("out_fifth_still", issue_ready, 0);
    wb_set(5'd1, 32'h1111_1111, 5'b0);
    settle();
    chk("out_fifth_wb", issue_ready, 1);
    tick();
    issue_valid = 1'b0; wb_clr();
    settle();
    chk("out_fifth_rd", fpu_rd, 7);
    chk("out_fifth_valid", fpu_valid, 1);
    do_wb(5'd2, 32'h0); do_wb(5'd3, 32'h0); do_wb(5'd4, 32'h0); do_wb(5'd7, 32'h0);

    // FPU back-pressure holds the staged op
    fpu_ready = 1'b0;
    issue_set(5'd0, 5'd0, 5'd9, 3'b001);
    tick();
    issue_set(5'd0, 5'd0, 5'd10, 3'b001);
    settle();
    chk("bp_stall", issue_ready, 0);
    tick();
    chk("bp_hold_rd", fpu_rd, 9);
    chk("bp_hold_valid", fpu_valid, 1);
    fpu_ready = 1'b1;
    settle();
    chk("bp_release", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    chk("bp_next_rd", fpu_rd, 10);
    do_wb(5'd9, 32'h0); do_wb(5'd10, 32'h0);

    // rounding-mode resolution table
    for (int v = 0; v < 9; v++) begin
      frm_we = 1'b1; frm_wdata = vecs[v].frm_v;
      tick();
      frm_we = 1'b0;
      chk("tbl_frm", frm, vecs[v].frm_v);
      issue_set(5'd0, 5'd0, 5'd12, vecs[v].rm);
      tick();
      issue_valid = 1'b0;
      st_rs = 5'd12;
      settle();
      chk("tbl_illegal", illegal_rm, vecs[v].exp_ill);
      chk("tbl_valid", fpu_valid, !vecs[v].exp_ill);
      chk("tbl_busy12", st_ok, vecs[v].exp_ill);
      if (!vecs[v].exp_ill) chk("tbl_fpu_frm", fpu_frm, vecs[v].exp_frm);
      tick();
      chk("tbl_pulse_end", illegal_rm, 0);
      if (!vecs[v].exp_ill) do_wb(5'd12, 32'h0);
    end

    // dynamic issue in the same cycle as frm_we uses the old frm
    frm_we = 1'b1; frm_wdata = 3'b010;
    tick();
    frm_wdata = 3'b001;
    issue_set(5'd0, 5'd0, 5'd12, 3'b111);
    tick();
    frm_we = 1'b0; issue_valid = 1'b0;
    chk("frm_same_cycle_old", fpu_frm, 3'b010);
    chk("frm_same_cycle_new", frm, 3'b001);
    do_wb(5'd12, 32'h0);

    // flag accumulation and write/wb merge
    chk("flags_clean", fflags, 0);
    issue_set(5'd0, 5'd0, 5'd13, 3'b000);
    tick();
    issue_valid = 1'b0;
    wb_set(5'd13, 32'h0, 5'b00001);
    tick();
    wb_clr();
    chk("flags_nx", fflags, 5'b00001);
    issue_set(5'd0, 5'd0, 5'd14, 3'b000);
    tick();
    issue_valid = 1'b0;
    wb_set(5'd14, 32'h0, 5'b10000);
    tick();
    wb_clr();
    chk("flags_accum", fflags, 5'b10001);
    issue_set(5'd0, 5'd0, 5'd15, 3'b000);
    tick();
    issue_valid = 1'b0;
    wb_set(5'd15, 32'h0, 5'b00100);
    fflags_we = 1'b1; fflags_wdata = 5'b00000;
    tick();
    wb_clr(); fflags_we = 1'b0;
    chk("flags_we_merge", fflags, 5'b00100);

    // spurious writeback to an idle register
    st_rs = 5'd20;
    wb_set(5'd20, 32'hDEAD_BEEF, 5'b0);
    tick();
    wb_clr();
    chk("spur_set", spurious_wb, 1);
    chk("spur_reg_kept", st_data, 0);
    tick();
    chk("spur_sticky", spurious_wb, 1);

    // writeback for a tag discarded by reset
    issue_set(5'd0, 5'd0, 5'd21, 3'b000);
    tick();
    issue_valid = 1'b0;
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    tick();
    chk("late_rst_clear", spurious_wb, 0);
    st_rs = 5'd21;
    wb_set(5'd21, 32'h1234_5678, 5'b0);
    tick();
    wb_clr();
    chk("late_wb_spur", spurious_wb, 1);
    chk("late_wb_dropped", st_data, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
